// File: rtl/elapsed_timer_mmss.sv
// MM:SS up-counting elapsed timer: four cascaded BCD digits stepped by a 1 Hz tick, start/stop/clear control,
// limit match. All outputs registered, one-edge latency; no backpressure, commands are level-sampled every clock.
module elapsed_timer_mmss (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic [15:0] limit_bcd,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        done,
  output logic        wrap
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] limit_q, limit_nxt;
  logic [15:0] count_nxt, inc_val;
  logic        inc_wrap, done_nxt, wrap_nxt, limit_ok;

  // Compares use >= so a digit can never step past its modulus.
  always_comb begin
    inc_val  = time_bcd;
    inc_wrap = 1'b0;
    if (time_bcd[3:0] >= 4'd9) begin
      inc_val[3:0] = 4'd0;
      if (time_bcd[7:4] >= 4'd5) begin
        inc_val[7:4] = 4'd0;
        if (time_bcd[11:8] >= 4'd9) begin
          inc_val[11:8] = 4'd0;
          if (time_bcd[15:12] >= 4'd5) begin
            inc_val[15:12] = 4'd0;
            inc_wrap       = 1'b1;
          end else begin
            inc_val[15:12] = time_bcd[15:12] + 4'd1;
          end
        end else begin
          inc_val[11:8] = time_bcd[11:8] + 4'd1;
        end
      end else begin
        inc_val[7:4] = time_bcd[7:4] + 4'd1;
      end
    end else begin
      inc_val[3:0] = time_bcd[3:0] + 4'd1;
    end
  end

  // A zero or non-BCD limit disables matching entirely.
  assign limit_ok = (limit_q != 16'h0000) &&
                    (limit_q[15:12] <= 4'd5) && (limit_q[11:8] <= 4'd9) &&
                    (limit_q[7:4]   <= 4'd5) && (limit_q[3:0]  <= 4'd9);

  always_comb begin
    state_nxt = state;
    count_nxt = time_bcd;
    limit_nxt = limit_q;
    done_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      count_nxt = 16'h0000;
    end else if (stop) begin
      if (state == RUNNING) state_nxt = PAUSED;
    end else if (start && (state == IDLE || state == PAUSED)) begin
      state_nxt = RUNNING;
      if (state == IDLE) limit_nxt = limit_bcd;
    end else if (tick && state == RUNNING) begin
      count_nxt = inc_val;
      wrap_nxt  = inc_wrap;
      if (limit_ok && inc_val == limit_q) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      limit_q  <= 16'h0000;
      time_bcd <= 16'h0000;
      running  <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nxt;
      limit_q  <= limit_nxt;
      time_bcd <= count_nxt;
      running  <= (state_nxt == RUNNING);
      done     <= done_nxt;
      wrap     <= wrap_nxt;
    end
  end

endmodule

// File: doc/elapsed_timer_mmss.md
# elapsed_timer_mmss

Up-counting MM:SS elapsed-time timer: four cascaded BCD digits (seconds units mod 10, seconds tens mod 6, minutes units mod 10, minutes tens mod 6) advanced by a one-clock-wide 1 Hz tick. It is the count-up counterpart of the timer's countdown digit chain, measuring how long an irrigation zone has actually run. It raises a one-cycle `done` pulse when the elapsed time equals a latched BCD limit. A start/stop/clear state machine controls it.

## Interface
- No parameters; widths fixed (4 BCD digits, 16-bit bus).
- `clock`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low; low forces all state and outputs to reset values immediately.
- `tick`  in  1  count enable, 1 clock wide, nominally 1 Hz.
- `start`  in  1  level-sampled each clock; begin or resume counting.
- `stop`  in  1  level-sampled; pause counting.
- `clear`  in  1  level-sampled; return to IDLE, count to 00:00.
- `limit_bcd`  in  16  target MM:SS: [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units.
- `time_bcd`  out  16  current elapsed time, same packing as `limit_bcd`.
- `running`  out  1  high in RUNNING.
- `done`  out  1  one-cycle pulse when count reaches the latched limit.
- `wrap`  out  1  one-cycle pulse when count rolls 59:59 -> 00:00.

## Operation
- States: IDLE, RUNNING, PAUSED, DONE. Reset state IDLE.
- Command priority each clock: `clear` > `stop` > `start` > `tick`.
- IDLE: `time_bcd` = 0000. `start` -> RUNNING; `limit_bcd` is latched into an internal register on this transition only. `tick` ignored.
- RUNNING: `tick` increments count. `stop` -> PAUSED. `clear` -> IDLE, count cleared.
- PAUSED: count held; `tick` ignored. `start` -> RUNNING; latched limit unchanged. `clear` -> IDLE.
- DONE: count held at limit; `tick`, `start`, and `stop` ignored. `clear` -> IDLE.
- Increment rules:
  - Sec units 9->0 carries into sec tens.
  - Sec tens 5->0 carries into min units.
  - Min units 9->0 carries into min tens.
  - Min tens 5->0 with all others rolling over = 59:59 -> 00:00. `wrap` pulses and counting continues.
- Match: after an increment, if new count == latched limit and latched limit != 0000, go to DONE and pulse `done`.
- Latched limit 0000: never matches; free-running with `wrap`.
- Limit containing invalid BCD (digit > 9, or tens digit > 5): never matches; behaves as free-running.
- Count digits never hold non-BCD values. Tens digits stay in 0..5 and units digits in 0..9 under all input sequences.

## Timing
- All outputs are registered.
- Reset values: `time_bcd` = 0000, `running` = 0, `done` = 0, `wrap` = 0; latched limit = 0000; state IDLE.
- A `tick` sampled high at edge N in RUNNING updates `time_bcd` after edge N.
- `done` and `wrap` are high for exactly the one cycle following edge N. `running` falls after edge N when a match occurs.
- State transitions take effect after the sampling edge. `running` follows state with the same one-edge latency.
- Simultaneous `tick` and `stop` in RUNNING: pause wins and the tick is dropped.
- Simultaneous `tick` and `start` in IDLE or PAUSED: transition only, no increment that cycle.
- Simultaneous `tick` and `clear`: count is 0000 after the edge, and no `done`/`wrap` pulse occurs.
- `reset` asserted mid-count: outputs reach reset values asynchronously. After release, the block waits in IDLE for `start`.
- `start` held high continuously does not restart from DONE; only `clear` leaves DONE.

## Test plan
- Reset then basic count: reset low, release; pulse `start`, then 75 ticks -> `time_bcd` = 0115, `running` = 1, no `done`/`wrap`.
- Limit match: `limit_bcd` = 0010 latched at start; 10 ticks -> `time_bcd` = 0010 and a `done` pulse 1 cycle wide. 5 further ticks -> count stays 0010, `running` = 0.
- Rollover: limit 0000, run to 5959, one more tick -> `time_bcd` = 0000 and a `wrap` pulse 1 cycle wide, with `running` still 1.
- Pause/resume and priority: at 0003 assert `stop` with `tick` on the same edge -> count stays 0003 in PAUSED. 3 ticks -> still 0003. `start` then 2 ticks -> 0005. Change `limit_bcd` while paused -> the new value is not used.
- Clear and async reset: assert `clear` together with `tick` at 0042 -> 0000, IDLE, no pulses. Run to 0020, drop `reset` between clock edges -> outputs are 0 before the next edge.
- Invalid limit: `limit_bcd` = 0070 -> count passes 0059 -> 0100 with no `done`.
